// File: rtl/asi_pkg.sv
// Shared AXI width constants and burst encodings for the asi read path.
package asi_pkg;
  localparam int AXI_IW     = 4;
  localparam int AXI_AW     = 32;
  localparam int AXI_LW     = 8;
  localparam int AXI_SW     = 3;
  localparam int AXI_BURSTW = 2;
  localparam int AXI_DW     = 32;
  localparam int AXI_RRESPW = 2;

  localparam logic [AXI_BURSTW-1:0] BURST_FIXED = 2'b00;
  localparam logic [AXI_BURSTW-1:0] BURST_INCR  = 2'b01;
  localparam logic [AXI_BURSTW-1:0] BURST_WRAP  = 2'b10;
endpackage

// File: rtl/asi_rd_burst_if.sv
// AXI4 read address and read data channels as one bundle.
interface asi_rd_burst_if;
  import asi_pkg::*;
  logic [AXI_IW-1:0]     ARID;
  logic [AXI_AW-1:0]     ARADDR;
  logic [AXI_LW-1:0]     ARLEN;
  logic [AXI_SW-1:0]     ARSIZE;
  logic [AXI_BURSTW-1:0] ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [AXI_IW-1:0]     RID;
  logic [AXI_DW-1:0]     RDATA;
  logic [AXI_RRESPW-1:0] RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/asi_rd_burst.sv
// AXI4 read slave: AR queue, FIXED/INCR/WRAP burst engine, latency-matched tag pipe
// and credit-limited RDATA buffer in front of a synchronous RAM.
module asi_rd_burst
  import asi_pkg::*;
#(
  parameter int SLV_OD = 4,
  parameter int SLV_RD = 8,
  parameter int SLV_WS = 2
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  asi_rd_burst_if.slave     axi,
  output logic              m_re,
  output logic [AXI_AW-1:0] m_raddr,
  input  logic [AXI_DW-1:0] m_rdata
);
  localparam int QPW = (SLV_OD > 1) ? $clog2(SLV_OD) : 1;
  localparam int QCW = $clog2(SLV_OD + 1);
  localparam int RPW = $clog2(SLV_RD);
  localparam int RCW = $clog2(SLV_RD + 1);
  localparam int FCW = $clog2(SLV_WS + 2);
  localparam logic [AXI_SW-1:0] MAX_SIZE = AXI_SW'($clog2(AXI_DW / 8));
  localparam logic [AXI_AW-1:0] ONE = 1;

  typedef struct packed {
    logic [AXI_IW-1:0]     id;
    logic [AXI_AW-1:0]     addr;
    logic [AXI_LW-1:0]     len;
    logic [AXI_SW-1:0]     size;
    logic [AXI_BURSTW-1:0] burst;
    logic                  err;
  } ar_t;
  typedef struct packed {
    logic [AXI_IW-1:0] id;
    logic              last;
    logic              err;
  } tag_t;
  typedef struct packed {
    logic [AXI_IW-1:0]     id;
    logic [AXI_DW-1:0]     data;
    logic [AXI_RRESPW-1:0] resp;
    logic                  last;
  } rb_t;
  typedef enum logic {IDLE, ISSUE} state_t;

  state_t         state;
  ar_t            arq [SLV_OD];
  ar_t            ar_in, ar_head;
  logic [QPW-1:0] q_wr, q_rd;
  logic [QCW-1:0] q_cnt, q_cnt_nxt;
  logic           arready_q, push, pop, len_ok;

  always_comb begin
    len_ok = (axi.ARLEN == AXI_LW'(1)) || (axi.ARLEN == AXI_LW'(3)) ||
             (axi.ARLEN == AXI_LW'(7)) || (axi.ARLEN == AXI_LW'(15));
    ar_in = '{id: axi.ARID, addr: axi.ARADDR, len: axi.ARLEN, size: axi.ARSIZE,
              burst: axi.ARBURST,
              err: (axi.ARBURST == 2'b11) || (axi.ARSIZE > MAX_SIZE) ||
                   ((axi.ARBURST == BURST_WRAP) && !len_ok)};
  end

  function automatic logic [QPW-1:0] q_inc(input logic [QPW-1:0] p);
    return (p == QPW'(SLV_OD - 1)) ? '0 : p + QPW'(1);
  endfunction

  assign push        = axi.ARVALID && arready_q;
  assign pop         = (state == IDLE) && (q_cnt != '0);
  assign q_cnt_nxt   = q_cnt + QCW'(push) - QCW'(pop);
  assign ar_head     = arq[q_rd];
  assign axi.ARREADY = arready_q;

  // ARREADY comes from the registered count, so a pop only frees a slot a cycle later
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      q_wr <= '0; q_rd <= '0; q_cnt <= '0; arready_q <= 1'b0;
    end else begin
      if (push) q_wr <= q_inc(q_wr);
      if (pop)  q_rd <= q_inc(q_rd);
      q_cnt     <= q_cnt_nxt;
      arready_q <= (q_cnt_nxt < QCW'(SLV_OD));
    end

  always_ff @(posedge ACLK)
    if (push) arq[q_wr] <= ar_in;

  logic [AXI_IW-1:0]     e_id;
  logic [AXI_AW-1:0]     cur, nxt, bytes, total, lo, head_bytes;
  logic [AXI_LW-1:0]     e_len, beat;
  logic [AXI_SW-1:0]     e_size;
  logic [AXI_BURSTW-1:0] e_burst;
  logic                  e_err, credit_ok, issue, arr_vld;
  logic [FCW-1:0]        inflight;
  logic [RCW-1:0]        rb_cnt;
  tag_t                  iss_tag, arr_tag;

  assign credit_ok = (int'(rb_cnt) + int'(inflight)) < SLV_RD;
  assign issue     = (state == ISSUE) && credit_ok;
  assign m_re      = issue && !e_err;
  assign m_raddr   = m_re ? cur : '0;
  assign iss_tag   = '{id: e_id, last: (beat == e_len), err: e_err};

  always_comb begin
    bytes      = ONE << e_size;
    total      = bytes * (AXI_AW'(e_len) + ONE);
    lo         = cur & ~(total - ONE);
    head_bytes = ONE << ar_head.size;
    case (e_burst)
      BURST_INCR: nxt = (cur & ~(bytes - ONE)) + bytes;
      BURST_WRAP: nxt = lo | ((cur + bytes) & (total - ONE));
      default:    nxt = cur;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state <= IDLE; e_id <= '0; cur <= '0; e_len <= '0; beat <= '0;
      e_size <= '0; e_burst <= '0; e_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          e_id    <= ar_head.id;
          cur     <= (ar_head.burst == BURST_WRAP) ? (ar_head.addr & ~(head_bytes - ONE))
                                                   : ar_head.addr;
          e_len   <= ar_head.len;
          e_size  <= ar_head.size;
          e_burst <= ar_head.burst;
          e_err   <= ar_head.err;
          beat    <= '0;
          state   <= ISSUE;
        end
        ISSUE: if (issue) begin
          cur  <= nxt;
          beat <= beat + AXI_LW'(1);
          if (beat == e_len) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end

  // Tags ride alongside the RAM access so each beat meets its data on arrival
  generate
    if (SLV_WS == 0) begin : g_ws0
      assign arr_vld  = issue;
      assign arr_tag  = iss_tag;
      assign inflight = '0;
    end else begin : g_ws
      logic [SLV_WS-1:0] vld_pipe;
      tag_t              tag_pipe [SLV_WS];
      always_ff @(posedge ACLK or negedge ARESETn)
        if (!ARESETn) begin
          vld_pipe <= '0;
          for (int i = 0; i < SLV_WS; i++) tag_pipe[i] <= '0;
        end else begin
          vld_pipe[0] <= issue;
          tag_pipe[0] <= iss_tag;
          for (int i = 1; i < SLV_WS; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
          end
        end
      always_comb begin
        inflight = '0;
        for (int i = 0; i < SLV_WS; i++) inflight = inflight + FCW'(vld_pipe[i]);
      end
      assign arr_vld = vld_pipe[SLV_WS-1];
      assign arr_tag = tag_pipe[SLV_WS-1];
    end
  endgenerate

  rb_t            rbuf [SLV_RD];
  rb_t            rb_head;
  logic [RPW-1:0] rb_wr, rb_rd;
  logic           rvalid, rpop;

  function automatic logic [RPW-1:0] rb_inc(input logic [RPW-1:0] p);
    return (p == RPW'(SLV_RD - 1)) ? '0 : p + RPW'(1);
  endfunction

  assign rvalid = (rb_cnt != '0);
  assign rpop   = rvalid && axi.RREADY;

  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      rb_wr <= '0; rb_rd <= '0; rb_cnt <= '0;
    end else begin
      if (arr_vld) rb_wr <= rb_inc(rb_wr);
      if (rpop)    rb_rd <= rb_inc(rb_rd);
      rb_cnt <= rb_cnt + RCW'(arr_vld) - RCW'(rpop);
    end

  always_ff @(posedge ACLK)
    if (arr_vld)
      rbuf[rb_wr] <= '{id: arr_tag.id, data: arr_tag.err ? '0 : m_rdata,
                       resp: arr_tag.err ? AXI_RRESPW'(2) : AXI_RRESPW'(0),
                       last: arr_tag.last};

  assign rb_head    = rbuf[rb_rd];
  assign axi.RVALID = rvalid;
  assign axi.RID    = rvalid ? rb_head.id   : '0;
  assign axi.RDATA  = rvalid ? rb_head.data : '0;
  assign axi.RRESP  = rvalid ? rb_head.resp : '0;
  assign axi.RLAST  = rvalid && rb_head.last;
endmodule

// File: tb/tb_asi_rd_burst.sv
// Directed bench for asi_rd_burst: expected RAM addresses and R beats are queued when
// each AR is driven and checked as the DUT produces them.
module tb_asi_rd_burst;
  import asi_pkg::*;
  localparam int OD = 4, RD = 8, WS = 2;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        m_re;
  logic [31:0] m_raddr, m_rdata, rp0, rp1;
  int          tests = 0, fails = 0, re_cnt = 0, r_cnt = 0, r_base;
  rbeat_t      rq[$];
  logic [31:0] aq[$];

  asi_rd_burst_if bus();
  asi_rd_burst #(.SLV_OD(OD), .SLV_RD(RD), .SLV_WS(WS)) dut (
    .ACLK(clk), .ARESETn(rst_n), .axi(bus.slave),
    .m_re(m_re), .m_raddr(m_raddr), .m_rdata(m_rdata));

  always #5 clk = ~clk;

  function automatic logic [31:0] ram_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A00_00C3;
  endfunction

  // RAM with two-cycle read latency
  always @(posedge clk) begin
    rp0 <= m_raddr;
    rp1 <= rp0;
  end
  assign m_rdata = ram_f(rp1);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    rbeat_t e;
    if (rst_n) begin
      if (m_re) begin
        re_cnt++;
        if (aq.size() == 0) chk("m_re_unexpected", m_re, 1'b0);
        else chk("m_raddr", m_raddr, aq.pop_front());
      end
      if (bus.RVALID && bus.RREADY) begin
        r_cnt++;
        if (rq.size() == 0) chk("r_unexpected", bus.RVALID, 1'b0);
        else begin
          e = rq.pop_front();
          chk("RID", bus.RID, e.id);
          chk("RDATA", bus.RDATA, e.data);
          chk("RRESP", bus.RRESP, e.resp);
          chk("RLAST", bus.RLAST, e.last);
        end
      end
    end
  end

  // Independent burst model: per-beat address from start, size and beat index
  task automatic push_exp(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst);
    logic        err;
    logic [31:0] b, al, tot, lo, a;
    rbeat_t      r;
    err = (burst == 2'b11) || (size > 2) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    b   = 32'd1 << size;
    al  = (addr / b) * b;
    tot = b * (len + 1);
    lo  = (al / tot) * tot;
    for (int n = 0; n <= len; n++) begin
      case (burst)
        2'b01:   a = (n == 0) ? addr : al + n * b;
        2'b10:   a = lo + ((al - lo + n * b) % tot);
        default: a = addr;
      endcase
      if (!err) aq.push_back(a);
      r.id = id; r.data = err ? 32'd0 : ram_f(a);
      r.resp = err ? 2'b10 : 2'b00; r.last = (n == len);
      rq.push_back(r);
    end
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst);
    @(posedge clk); #1;
    push_exp(id, addr, len, size, burst);
    bus.ARID = id; bus.ARADDR = addr; bus.ARLEN = 8'(len);
    bus.ARSIZE = 3'(size); bus.ARBURST = burst; bus.ARVALID = 1'b1;
  endtask

  task automatic wait_ar_hs(input string tag, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ARREADY) begin ok = 1; break; end
    end
    if (!ok) chk({tag, "_ar_timeout"}, bus.ARREADY, 1'b1);
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic send_ar(input string tag, input logic [3:0] id, input logic [31:0] addr,
                         input int len, input int size, input logic [1:0] burst);
    drive_ar(id, addr, len, size, burst);
    wait_ar_hs(tag, 50);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rq.size() == 0 && aq.size() == 0) break;
    end
    chk({tag, "_drain"}, 64'(rq.size() + aq.size()), 64'd0);
  endtask

  initial begin
    bus.ARVALID = 0; bus.RREADY = 0; bus.ARID = 0; bus.ARADDR = 0;
    bus.ARLEN = 0; bus.ARSIZE = 0; bus.ARBURST = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ARREADY", bus.ARREADY, 0); chk("rst_RVALID", bus.RVALID, 0);
    chk("rst_RLAST", bus.RLAST, 0);     chk("rst_m_re", m_re, 0);
    chk("rst_RID", bus.RID, 0);         chk("rst_RDATA", bus.RDATA, 0);
    chk("rst_RRESP", bus.RRESP, 0);     chk("rst_m_raddr", m_raddr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("arready_release_cycle", bus.ARREADY, 0);
    @(negedge clk); chk("arready_after_release", bus.ARREADY, 1);

    // INCR unaligned start, with latency checks
    bus.RREADY = 1'b1;
    send_ar("incr", 4'h1, 32'h1002, 3, 2, BURST_INCR);
    @(negedge clk); chk("lat_c1_mre", m_re, 0);
    @(negedge clk); chk("lat_c2_mre", m_re, 1);
    @(negedge clk);
    @(negedge clk); chk("lat_c4_rvalid", bus.RVALID, 0);
    @(negedge clk); chk("lat_c5_rvalid", bus.RVALID, 1);
    wait_drain("incr", 100);

    send_ar("wrap", 4'h2, 32'h38, 3, 2, BURST_WRAP);
    wait_drain("wrap", 100);
    send_ar("fixed", 4'h3, 32'h40, 2, 2, BURST_FIXED);
    wait_drain("fixed", 100);

    re_cnt = 0;
    send_ar("wrap_len2", 4'h4, 32'h50, 2, 2, BURST_WRAP);
    send_ar("big_size", 4'h5, 32'h60, 1, 3, BURST_INCR);
    send_ar("burst3", 4'h6, 32'h70, 0, 2, 2'b11);
    wait_drain("err", 200);
    chk("err_no_mre", re_cnt, 0);

    send_ar("incr_wrap32", 4'h7, 32'hFFFF_FFF8, 3, 2, BURST_INCR);
    send_ar("incr_byte", 4'h8, 32'h103, 3, 0, BURST_INCR);
    send_ar("wrap8", 4'h9, 32'h0E, 7, 1, BURST_WRAP);
    wait_drain("mix", 300);

    // Credit limit with R stalled
    bus.RREADY = 1'b0; re_cnt = 0; r_base = r_cnt;
    send_ar("credit", 4'hA, 32'h2000, 15, 2, BURST_INCR);
    repeat (30) @(negedge clk);
    chk("credit_mre", re_cnt, RD);
    chk("credit_rvalid", bus.RVALID, 1);
    @(posedge clk); #1 bus.RREADY = 1'b1;
    wait_drain("credit", 200);
    chk("credit_beats", r_cnt - r_base, 16);

    // AR queue fill with R stalled
    bus.RREADY = 1'b0; r_base = r_cnt;
    for (int i = 0; i < 6; i++)
      send_ar("od", 4'(i), 32'h3000 + 32'(i) * 32'h100, 7, 2, BURST_INCR);
    repeat (5) @(negedge clk);
    drive_ar(4'h6, 32'h3600, 7, 2, BURST_INCR);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("od_full_arready", bus.ARREADY, 0);
    end
    @(posedge clk); #1 bus.RREADY = 1'b1;
    wait_ar_hs("ar7", 200);
    wait_drain("od", 800);
    chk("od_beats", r_cnt - r_base, 56);

    // Reset in the middle of a stalled burst
    bus.RREADY = 1'b0;
    send_ar("pre_rst", 4'hC, 32'h4000, 15, 2, BURST_INCR);
    repeat (4) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_RVALID", bus.RVALID, 0);
    chk("midrst_m_re", m_re, 0);
    chk("midrst_ARREADY", bus.ARREADY, 0);
    rq.delete(); aq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.RREADY = 1'b1; r_base = r_cnt;
    send_ar("post_rst", 4'hD, 32'h5000, 3, 2, BURST_INCR);
    wait_drain("post_rst", 100);
    repeat (20) @(negedge clk);
    chk("post_rst_beats", r_cnt - r_base, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
